seq_detector_param: RTL and testbench

//  Serial bit-pattern detector with parametrised pattern length, per-bit don't-care mask,

---
 rtl/seq_detector_param_if.sv | 30 +++
 rtl/seq_detector_param.sv | 106 ++++++++++
 tb/tb_seq_detector_param.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// Control, configuration and serial-bit bundle between the bit source / event logic and the detector.
// The master drives config, control and bits; the slave (detector) returns found, match_count and busy.
interface seq_detector_param_if #(
   parameter int W     = 8,
   parameter int CNT_W = 8
);
   logic             cfg_load;
   logic [W-1:0]     cfg_pattern;
   logic [W-1:0]     cfg_mask;
   logic             cfg_overlap;
   logic             start;
   logic             stop;
   logic             bit_valid;
   logic             bit_in;
   logic             found;
   logic [CNT_W-1:0] match_count;
   logic             busy;

   modport master (
      output cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
      output start, stop, bit_valid, bit_in,
      input  found, match_count, busy
   );

   modport slave (
      input  cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
      input  start, stop, bit_valid, bit_in,
      output found, match_count, busy
   );
endinterface

// File: rtl/seq_detector_param.sv
// Masked serial pattern detector with overlap select and saturating hit counter.
// found is registered, 1 cycle after the completing bit; no backpressure, a bit is consumed whenever bit_valid is high.
module seq_detector_param #(
   parameter int W     = 8,
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   seq_detector_param_if.slave bus
);
   localparam int FW = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_HUNT
   } state_t;

   state_t           r_state,   w_state_nxt;
   logic [W-1:0]     r_shift,   w_shift_nxt;
   logic [W-1:0]     r_pattern, w_pattern_nxt;
   logic [W-1:0]     r_mask,    w_mask_nxt;
   logic             r_overlap, w_overlap_nxt;
   logic             r_found,   w_found_nxt;
   logic [FW-1:0]    r_fill,    w_fill_nxt;
   logic [CNT_W-1:0] r_count,   w_count_nxt;

   logic [W-1:0]     w_shifted;
   logic [FW-1:0]    w_fill_inc;
   logic             w_hit;

   // Candidate window and fill level as they would be if the current bit is taken.
   always_comb begin
      w_shifted  = {r_shift[W-2:0], bus.bit_in};
      w_fill_inc = (r_fill == FW'(W)) ? r_fill : r_fill + FW'(1);
      w_hit      = (w_fill_inc == FW'(W)) && (((w_shifted ^ r_pattern) & r_mask) == '0);
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_pattern_nxt = r_pattern;
      w_mask_nxt    = r_mask;
      w_overlap_nxt = r_overlap;
      w_fill_nxt    = r_fill;
      w_count_nxt   = r_count;
      w_found_nxt   = 1'b0;

      if (bus.stop) begin
         // stop overrides a simultaneous start: search ends, counters and window untouched.
         w_state_nxt = S_IDLE;
      end else if (bus.start) begin
         w_state_nxt = S_FILL;
         w_shift_nxt = '0;
         w_fill_nxt  = '0;
         w_count_nxt = '0;
      end else if (bus.cfg_load && (r_state == S_IDLE)) begin
         w_pattern_nxt = bus.cfg_pattern;
         w_mask_nxt    = bus.cfg_mask;
         w_overlap_nxt = bus.cfg_overlap;
      end else if (bus.bit_valid && (r_state != S_IDLE)) begin
         w_shift_nxt = w_shifted;
         w_fill_nxt  = w_fill_inc;
         if (w_fill_inc == FW'(W)) begin
            w_state_nxt = S_HUNT;
         end
         if (w_hit) begin
            w_found_nxt = 1'b1;
            if (r_count != '1) begin
               w_count_nxt = r_count + CNT_W'(1);
            end
            // Non-overlapping mode needs W fresh bits before the next hit.
            if (!r_overlap) begin
               w_fill_nxt  = '0;
               w_state_nxt = S_FILL;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_pattern <= '0;
         r_mask    <= '0;
         r_overlap <= 1'b0;
         r_fill    <= '0;
         r_count   <= '0;
         r_found   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_pattern <= w_pattern_nxt;
         r_mask    <= w_mask_nxt;
         r_overlap <= w_overlap_nxt;
         r_fill    <= w_fill_nxt;
         r_count   <= w_count_nxt;
         r_found   <= w_found_nxt;
      end
   end

   assign bus.found       = r_found;
   assign bus.match_count = r_count;
   assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (W=8, CNT_W=2); expected found pulses are queued per driven cycle.
module tb_seq_detector_param;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seq_detector_param_if #(.W(8), .CNT_W(2)) bus ();

   seq_detector_param #(.W(8), .CNT_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   logic exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [7:0] pat, input logic [7:0] msk, input logic ovl);
      bus.cfg_pattern = pat;
      bus.cfg_mask    = msk;
      bus.cfg_overlap = ovl;
   endtask

   // One clock: drive controls/bit, queue the expected found for the following edge, then check it.
   task automatic step(input logic st, input logic sp, input logic ld,
                       input logic v, input logic b, input logic exp_f, input string tag);
      logic e;
      @(negedge clk);
      bus.start     = st;
      bus.stop      = sp;
      bus.cfg_load  = ld;
      bus.bit_valid = v;
      bus.bit_in    = b;
      exp_q.push_back(exp_f);
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.cfg_load  = 1'b0;
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 32'(bus.found), 32'(e));
      end
   endtask

   // Send n bits MSB first; hits[i] is the expected found after bit i.
   task automatic send(input logic [31:0] bits, input int n, input logic [31:0] hits, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, bits[i], hits[i], tag);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_load  = 1'b0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      set_cfg(8'h00, 8'h00, 1'b0);

      #12;
      chk("rst_found", 32'(bus.found), 32'd0);
      chk("rst_count", 32'(bus.match_count), 32'd0);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exact pattern, single pulse.
      set_cfg(8'hA5, 8'hFF, 1'b1);
      step(0, 0, 1, 0, 0, 0, "a5_load");
      step(1, 0, 0, 0, 0, 0, "a5_start");
      chk("a5_busy", 32'(bus.busy), 32'd1);
      send(32'hA5, 8, 32'h1, "a5_bits");
      chk("a5_count", 32'(bus.match_count), 32'd1);
      step(0, 0, 0, 0, 0, 0, "a5_pulse_end");

      // Overlapping AA.
      step(0, 1, 0, 0, 0, 0, "aa_stop");
      chk("aa_idle", 32'(bus.busy), 32'd0);
      set_cfg(8'hAA, 8'hFF, 1'b1);
      step(0, 0, 1, 0, 0, 0, "aa_load");
      step(1, 0, 0, 0, 0, 0, "aa_start");
      send(32'h2AA, 10, 32'h5, "aa_ovl_bits");
      chk("aa_ovl_count", 32'(bus.match_count), 32'd2);

      // Non-overlapping AA.
      step(0, 1, 0, 0, 0, 0, "aa_stop2");
      set_cfg(8'hAA, 8'hFF, 1'b0);
      step(0, 0, 1, 0, 0, 0, "aa_load2");
      step(1, 0, 0, 0, 0, 0, "aa_start2");
      send(32'h2AA, 10, 32'h4, "aa_novl_bits");
      chk("aa_novl_count", 32'(bus.match_count), 32'd1);

      // Mask: low nibble don't care.
      step(0, 1, 0, 0, 0, 0, "mask_stop");
      set_cfg(8'hF0, 8'hF0, 1'b1);
      step(0, 0, 1, 0, 0, 0, "mask_load");
      step(1, 0, 0, 0, 0, 0, "mask_start");
      send(32'hF6, 8, 32'h1, "mask_hit");
      chk("mask_hit_count", 32'(bus.match_count), 32'd1);
      step(1, 0, 0, 0, 0, 0, "mask_restart");
      send(32'hE0, 8, 32'h0, "mask_miss");
      chk("mask_miss_count", 32'(bus.match_count), 32'd0);

      // Gaps between valid bits.
      step(0, 1, 0, 0, 0, 0, "gap_stop");
      set_cfg(8'hA5, 8'hFF, 1'b1);
      step(0, 0, 1, 0, 0, 0, "gap_load");
      step(1, 0, 0, 0, 0, 0, "gap_start");
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] p;
         p = 8'hA5;
         step(0, 0, 0, 1, p[i], (i == 0), "gap_bit");
         step(0, 0, 0, 0, 0, 0, "gap_idle");
      end
      chk("gap_count", 32'(bus.match_count), 32'd1);

      // Mask 0: every bit after fill hits; counter saturates at 3.
      step(0, 1, 0, 0, 0, 0, "sat_stop");
      set_cfg(8'h00, 8'h00, 1'b1);
      step(0, 0, 1, 0, 0, 0, "sat_load");
      step(1, 0, 0, 0, 0, 0, "sat_start");
      for (int i = 0; i < 18; i++) begin
         step(0, 0, 0, 1, 1'($urandom), (i >= 7), "sat_bits");
      end
      chk("sat_count", 32'(bus.match_count), 32'd3);
      step(1, 0, 0, 0, 0, 0, "sat_restart");
      chk("sat_restart_count", 32'(bus.match_count), 32'd0);

      // cfg_load while searching is ignored.
      send($urandom, 8, 32'h1, "hunt_fill");
      set_cfg(8'hA5, 8'hFF, 1'b0);
      step(0, 0, 1, 0, 0, 0, "hunt_load");
      chk("hunt_busy", 32'(bus.busy), 32'd1);
      step(0, 0, 0, 1, 1'($urandom), 1, "hunt_still_mask0");
      chk("hunt_count", 32'(bus.match_count), 32'd2);
      step(0, 1, 0, 0, 0, 0, "hold_stop");
      chk("hold_count", 32'(bus.match_count), 32'd2);
      chk("hold_busy", 32'(bus.busy), 32'd0);

      // cfg_load with start in IDLE: start wins, config unchanged.
      step(1, 0, 1, 0, 0, 0, "ldst_start");
      send($urandom, 8, 32'h1, "ldst_bits");
      chk("ldst_count", 32'(bus.match_count), 32'd1);

      // Mid-stream stop, then a load in IDLE is accepted.
      send($urandom, 3, 32'h7, "mid_bits");
      step(0, 1, 0, 0, 0, 0, "mid_stop");
      set_cfg(8'hA5, 8'hFF, 1'b1);
      step(0, 0, 1, 0, 0, 0, "mid_load");
      step(1, 0, 0, 0, 0, 0, "mid_start");
      send(32'hA4, 8, 32'h0, "mid_a4");
      chk("mid_a4_count", 32'(bus.match_count), 32'd0);
      step(1, 0, 0, 0, 0, 0, "mid_restart");
      send(32'hA5, 8, 32'h1, "mid_a5");
      chk("mid_a5_count", 32'(bus.match_count), 32'd1);

      // start+stop together: IDLE, count kept.
      step(1, 1, 0, 0, 0, 0, "stst");
      chk("stst_busy", 32'(bus.busy), 32'd0);
      chk("stst_count", 32'(bus.match_count), 32'd1);

      // Async reset mid-search wipes state and config.
      step(1, 0, 0, 0, 0, 0, "ar_start");
      send(32'hA, 4, 32'h0, "ar_bits");
      chk("ar_pre_busy", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_busy",  32'(bus.busy), 32'd0);
      chk("ar_count", 32'(bus.match_count), 32'd0);
      chk("ar_found", 32'(bus.found), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 0, 0, 0, "ar_restart");
      send($urandom, 8, 32'h1, "ar_cfg_lost");
      chk("ar_cfg_lost_count", 32'(bus.match_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
